// File: rtl/pack_qam16.sv
// pack_qam16 -- QAM16 receive-side symbol gatherer.
// Collects eight 4-bit symbols (first symbol in the least-significant nibble)
// into one 32-bit word. The word is offered downstream with a valid/ack
// handshake. A one-cycle pulse flags a word broken by an input gap, and
// another flags a completed word dropped because the output was still full.

module pack_qam16 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_i,
    input  logic [3:0]  data_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    input  logic        ack_o,
    output logic        err_o,
    output logic        ovf_o
);

    // Two one-hot states: waiting for the first symbol of a word, or mid-word.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b01,
        S_ACTIVE = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;      // number of symbols already held
    // Only the seven most recent symbols can contribute to a word, because the
    // eighth symbol is taken straight from data_i. The register is therefore
    // 28 bits wide.
    logic [27:0] sr_q, sr_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic        complete;

    // Next-state logic for the symbol counter, the shift register and the output word.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves
        // a value unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        valid_d  = valid_q;
        data_d   = data_q;
        err_d    = 1'b0;
        ovf_d    = 1'b0;
        complete = 1'b0;

        if (valid_i) begin
            sr_d = {data_i, sr_q[27:4]};
        end

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    cnt_d   = 3'd1;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!valid_i) begin
                    // A gap inside a word: drop the partial word and report it.
                    cnt_d   = 3'd0;
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q == 3'd7) begin
                    complete = 1'b1;
                    cnt_d    = 3'd0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                cnt_d   = 3'd0;
                state_d = S_IDLE;
            end
        endcase

        // Output slot. A completion may reuse the slot when it is empty or is
        // being emptied in this same cycle. Otherwise the new word is dropped.
        if (complete) begin
            if (!valid_q || ack_o) begin
                valid_d = 1'b1;
                data_d  = {data_i, sr_q};
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && ack_o) begin
            valid_d = 1'b0;
        end
    end

    // State registers, cleared by the asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments, so every register
        // samples the values from before the edge.
        if (!RST) begin
            // NOTE: the shift register is reset along with the control state.
            // This gives the documented all-zero power-up contents.
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            sr_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign err_o   = err_q;
    assign ovf_o   = ovf_q;

endmodule

// File: doc/pack_qam16.md
Name: pack_qam16

Overview:
Receive-side symbol gatherer for the QAM16 modem path. It takes the demodulated 4-bit symbol stream, one symbol per valid cycle, first symbol in the least-significant nibble. It reassembles each group of 8 symbols into one 32-bit word and presents the word to the downstream consumer with a valid/ack handshake. It sits between the QAM16 demapper and the word-level RX buffer, and flags broken frames and overruns.

Parameters:
None. Symbol width is fixed at 4 and word width at 32 by the QAM16 framing (8 symbols per word).

Ports:
CLK      input   1   system clock, all logic on rising edge
RST      input   1   asynchronous, active-low reset
valid_i  input   1   data_i carries a symbol this cycle; no backpressure on this side
data_i   input   4   QAM16 symbol, first symbol of a word = bits [3:0]
valid_o  output  1   data_o holds a complete word
data_o   output  32  reassembled word
ack_o    input   1   consumer takes data_o this cycle when valid_o=1
err_o    output  1   1-cycle pulse: word broken by a valid_i gap (partial discarded)
ovf_o    output  1   1-cycle pulse: completed word dropped because output still occupied

Behaviour:
- One clock (CLK). Reset RST is asynchronous, active-low.
- Reset values:
  - state=s_idle, counter=0, shift register=0.
  - valid_o=0, data_o=32'h0, err_o=0, ovf_o=0.
  - Reset mid-word discards the partial word and any unacked output word.
- State machine, two one-hot states plus a 3-bit counter (number of symbols already held):
  - s_idle:
    - valid_i=1: shift in, counter<=1, go to s_active.
    - Otherwise hold.
  - s_active with valid_i=1 and counter<7: shift in, counter+1.
  - s_active with valid_i=1 and counter==7: word complete, counter<=0, go to s_idle.
  - s_active with valid_i=0: partial word dropped, counter<=0, go to s_idle, err_o=1 for the next cycle.
- Shift rule: sr <= {data_i, sr[31:4]}. After 8 shifts, the first symbol sits in [3:0] and the last in [31:28].
- Completion:
  - The candidate word is {data_i, sr[31:4]}, formed from the 8th symbol.
  - It is registered into data_o with valid_o=1 on the same clock edge.
  - Latency: valid_o rises 1 cycle after the 8th symbol is sampled.
- Output handshake:
  - Transfer happens in any cycle where valid_o=1 and ack_o=1.
  - After a transfer without a simultaneous completion, valid_o=0 next cycle and data_o holds its last value.
  - valid_o=0: ack_o is ignored.
  - Completion while valid_o=0: load the word.
  - Completion while valid_o=1 and ack_o=1 in the same cycle: old word consumed, new word loaded, valid_o stays 1, no ovf.
  - Completion while valid_o=1 and ack_o=0: new word dropped, data_o and valid_o unchanged, ovf_o=1 for the next cycle.
- Back-to-back words: continuous valid_i across a word boundary has no bubble. The 9th symbol is taken from s_idle as position 0.
- err_o and ovf_o can pulse in the same cycle only from independent events. Each is exactly one cycle wide and never sticky.
- The counter wraps only through the completion path. It never exceeds 7.

Test Plan:
1. Word assembly: ack_o=1, symbols 1,2,3,4,5,6,8,7 on 8 contiguous cycles -> next cycle valid_o=1, data_o=32'h78654321; valid_o=0 the cycle after.
2. Back-to-back words: ack_o=1, 16 contiguous symbols F,E,E,B,D,A,E,D,7,6,5,4,3,2,1,0 -> data_o=32'hDEADBEEF, then exactly 8 cycles later 32'h01234567; no err_o, no ovf_o.
3. Gap after 3 symbols: valid_i drops after 3 symbols -> err_o=1 for exactly one cycle, no valid_o. Following 8 symbols 0..7 -> data_o=32'h76543210.
4. Overrun with ack_o=0: 16 contiguous symbols -> first word held on data_o, ovf_o=1 for one cycle after the 16th symbol, data_o unchanged. Asserting ack_o then -> valid_o=0.
5. Same-cycle ack and completion: ack_o=1 exactly on the cycle the second word completes -> valid_o stays 1, data_o switches to the second word, ovf_o=0.
6. Reset mid-word: RST low asynchronously after 5 symbols with an unacked word pending -> valid_o=0, data_o=0 immediately. After release, 8 symbols A..H-free pattern 9,9,9,9,9,9,9,9 -> data_o=32'h99999999.
